hex_display_scanner: RTL
========================

# hex_display_scanner

- Parametrised, time-multiplexed driver for a bank of seven-segment hex digits.
- Takes a packed nibble vector through a load strobe and holds it in a shadow register.
- Commits the shadow to the displayed value only at a frame boundary, so no digit ever shows a half-updated value.
- Scans one digit per slot, with a ghost-suppression gap between slots. Sits between the CPU's display/debug register and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 4: digits scanned; legal 1..8.
- SCAN_DIV, 50000: clock cycles each digit is driven; legal ≥ 2.
- GUARD_CYC, 16: cycles with all anodes off between digits; legal ≥ 1.
- ACTIVE_LOW, 1: when 1, `seg`, `dp` and `an` are asserted low; when 0, asserted high.
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; captures `value` and `dp_in` into the shadow register.
- value  input  4*NUM_DIGITS  nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit.
- seg  output  7  segments, bit order g f e d c b a (bit 0 = a).
- dp  output  1  decimal point of the currently driven digit.
- an  output  NUM_DIGITS  one-hot digit enable.
- frame_start  output  1  one-cycle pulse when digit 0 begins its guard slot, which is also the commit cycle.

## Operation
- Glyphs, active-high, before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- FSM states:
  - RST: entered on reset. Leaves on the first clock after `rst_n` is released, entering GUARD with idx=0.
  - GUARD: lasts GUARD_CYC cycles. All `an`, `seg` and `dp` are inactive.
  - DRIVE: lasts SCAN_DIV cycles. `an[idx]` is active; `seg`/`dp` show digit idx of the active value.
  - When DRIVE ends, idx advances to (idx+1) mod NUM_DIGITS and the FSM enters GUARD.
- Slot counter width: $clog2(max(SCAN_DIV, GUARD_CYC)). It reloads on every state change.
- Frame boundary is each entry into GUARD with idx=0, including the first one after reset. At that cycle:
  - `frame_start`=1.
  - If the pending flag is set, the shadow is copied to the active register and pending is cleared.
- Load rules:
  - `load` writes the shadow and sets pending.
  - If `load` is asserted during pending, the last load wins.
  - If `load` is asserted in the commit cycle, the new `value`/`dp_in` are committed directly and pending stays clear.
- NUM_DIGITS=1: every slot transition is a frame boundary.
- Reset mid-operation: state, counters, idx, shadow, active, pending and `frame_start` clear immediately. All outputs go inactive asynchronously.

## Timing
- All outputs are registered and have no combinational path from inputs.
- Reset values:
  - `seg`, `dp`, `an` at inactive level (all 1s when ACTIVE_LOW=1).
  - `frame_start`=0.
  - Active and shadow registers are 0, so the first frame displays 0000.
- Load-to-display latency: at most one frame plus one cycle, where one frame = NUM_DIGITS*(SCAN_DIV+GUARD_CYC) cycles.
- `an` is never active in two digits at once, and never active during GUARD.

## Configuration
- HEX_SCAN_LZB_EN (leading-zero blanking):
  - Defined: every digit above the most significant nonzero nibble of the active value shows blank segments. Its `an` still pulses and its `dp` still follows `dp_in`. Digit 0 is never blanked, so the value 0 shows a single "0".
  - Undefined: all digits always show their glyph, and the blanking logic is not generated.

## Structure
- Package `seg7_pkg`:
  - glyph constant array (16 entries, 7 bits) and a BLANK constant;
  - FSM state typedef (RST, GUARD, DRIVE).
- Sub-module `seg7_glyph`: combinational nibble → 7-bit active-high glyph with a blank input. Polarity is applied in the parent output register.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYC=1, ACTIVE_LOW=1.
- Reset, then release → each frame lasts 20 cycles. `an` sequence per frame is 1111, 1110×4, 1111, 1101×4, 1111, 1011×4, 1111, 0111×4. `seg`=7'b1000000 (glyph 0 inverted) in every drive slot.
- Load value=16'h1A2F mid-frame → current frame still shows 0000. From the next `frame_start`, digits 0..3 show 71, 5B, 77, 06 before inversion.
- Two loads in the same frame (16'h1111, then 16'h2222) → only 2222 is ever displayed.
- Load 16'hBEEF in the exact `frame_start` cycle → BEEF is displayed in that same frame and no pending carries over to the next frame.
- HEX_SCAN_LZB_EN defined, load 16'h0030 → digits 3 and 2 blank (seg=7F), digit 1 shows 4F, digit 0 shows 3F. With the macro undefined, all four digits show glyphs.
- Assert `rst_n` low mid-DRIVE → `an`=1111 within the same cycle. After release, scan restarts at digit 0 showing 0000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment hex scanner: glyph table,
// blank pattern and scan FSM state type.
package seg7_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    // All segments off, active-high form
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high glyphs, bit order g f e d c b a (bit 0 = a)
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Larger of two integers, used to size the slot counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-high seven-segment glyph decoder with a
// blank override. Output polarity is handled by the parent.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph
);

    // Table lookup, forced to all-off when blanked
    always_comb begin
        glyph = SEG_BLANK;
        if (blank) begin
            glyph = SEG_BLANK;
        end else begin
            glyph = GLYPH_TABLE[nibble];
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed seven-segment hex display driver.
// A load strobe writes a shadow register; the shadow is committed to the
// displayed value only at the frame boundary (digit 0 entering its guard
// slot), so a digit never shows a half-updated value. Each digit is driven
// for SCAN_DIV cycles, separated by GUARD_CYC cycles of all-anodes-off.
// Optional feature: define HEX_SCAN_LZB_EN to blank leading zero digits.
module hex_display_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD_CYC  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CNT_MAX = max_int(SCAN_DIV, GUARD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SCAN_RELOAD  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_RELOAD = CNT_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

    // Inversion mask: XOR with this turns an active-high pattern into pin level
    localparam logic INV = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [6:0]            SEG_OFF = {7{INV}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{INV}};
    localparam logic                  DP_OFF  = INV;

    scan_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0]    shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0]    active_q, active_d;
    logic [NUM_DIGITS-1:0]      active_dp_q, active_dp_d;
    logic                       pending_q, pending_d;

    logic                       frame_start_q, frame_start_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       dp_q, dp_d;
    logic [NUM_DIGITS-1:0]      an_q, an_d;

    logic [3:0]                 nibble_s;
    logic                       blank_s;
    logic [6:0]                 glyph_s;

    // Scan sequencing: slot counter, digit index and state transitions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_GUARD;
                cnt_d   = GUARD_RELOAD;
                idx_d   = '0;
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRIVE;
                    cnt_d   = SCAN_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GUARD;
                    cnt_d   = GUARD_RELOAD;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Frame boundary: the cycle digit 0 enters its guard slot
    always_comb begin
        frame_start_d = 1'b0;
        if ((state_d == ST_GUARD) && (state_q != ST_GUARD) && (idx_d == '0)) begin
            frame_start_d = 1'b1;
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // Shadow/pending/active update. The commit happens at the end of the
    // frame_start cycle; a load landing in that same cycle bypasses the
    // shadow and is committed directly, leaving nothing pending.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pending_d   = pending_q;
        if (frame_start_q) begin
            if (load) begin
                shadow_d    = value;
                shadow_dp_d = dp_in;
                active_d    = value;
                active_dp_d = dp_in;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                active_d    = shadow_q;
                active_dp_d = shadow_dp_q;
                pending_d   = 1'b0;
            end else begin
                pending_d   = 1'b0;
            end
        end else if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
            pending_d   = 1'b1;
        end else begin
            pending_d   = pending_q;
        end
    end

    assign nibble_s = active_d[4*idx_d +: 4];

`ifdef HEX_SCAN_LZB_EN
    logic [IDX_W-1:0] top_digit_s;

    // Index of the most significant nonzero nibble (0 when the value is 0)
    always_comb begin
        top_digit_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (active_d[4*i +: 4] != 4'h0) begin
                top_digit_s = IDX_W'(i);
            end else begin
                top_digit_s = top_digit_s;
            end
        end
    end

    assign blank_s = (idx_d > top_digit_s);
`else
    assign blank_s = 1'b0;
`endif

    seg7_glyph u_glyph (
        .nibble (nibble_s),
        .blank  (blank_s),
        .glyph  (glyph_s)
    );

    // Pin-level outputs for the next cycle; everything off outside DRIVE
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (state_d == ST_DRIVE) begin
            an_d  = (NUM_DIGITS'(1) << idx_d) ^ AN_OFF;
            seg_d = glyph_s ^ SEG_OFF;
            dp_d  = active_dp_d[idx_d] ^ DP_OFF;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end
    end

    // State, data and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            active_q      <= '0;
            active_dp_q   <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            active_q      <= active_d;
            active_dp_q   <= active_dp_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
